// File: rtl/lp_filter_mc_if.sv
// Sample stream bundle for the multi-channel low-pass filter.
// The upstream side drives CE and the IN_* group; the filter drives the OUT_* group.
interface lp_filter_mc_if #(
    parameter int IN_DATA_BITS  = 28,
    parameter int OUT_DATA_BITS = 28,
    parameter int CHANNEL_BITS  = 2
);
    // Handshake: a sample transfers on a clock edge where CE=1 and IN_VALID=1.
    // There is no backpressure. OUT_VALID pulses once per sample, and OUT_* hold in between.
    logic                     CE;
    logic                     IN_VALID;
    logic [CHANNEL_BITS-1:0]  IN_CHANNEL;
    logic [IN_DATA_BITS-1:0]  IN_VALUE;
    logic [3:0]               SHIFT;
    logic                     OUT_VALID;
    logic [CHANNEL_BITS-1:0]  OUT_CHANNEL;
    logic [OUT_DATA_BITS-1:0] OUT_VALUE;

    modport master (
        output CE, IN_VALID, IN_CHANNEL, IN_VALUE, SHIFT,
        input  OUT_VALID, OUT_CHANNEL, OUT_VALUE
    );

    modport slave (
        input  CE, IN_VALID, IN_CHANNEL, IN_VALUE, SHIFT,
        output OUT_VALID, OUT_CHANNEL, OUT_VALUE
    );
endinterface

// File: rtl/lp_filter_mc.sv
// Time-multiplexed cascade of exponential smoothing stages with per-channel accumulators.
// Each stage does a one-cycle read-modify-write, so back-to-back samples of a channel are safe.
module lp_filter_mc #(
    parameter int IN_DATA_BITS   = 28,
    parameter int OUT_DATA_BITS  = 28,
    parameter int MAX_SHIFT      = 8,
    parameter int STAGE_COUNT    = 2,
    parameter int CHANNEL_BITS   = 2,
    parameter int PRIME_ON_FIRST = 1
) (
    input logic           CLK,
    input logic           RESET,
    lp_filter_mc_if.slave bus
);
    localparam int W   = OUT_DATA_BITS;
    localparam int F   = MAX_SHIFT;
    localparam int A   = W + F;
    localparam int NCH = 1 << CHANNEL_BITS;

    logic [W-1:0] in_padded;
    assign in_padded = W'(bus.IN_VALUE) << (W - IN_DATA_BITS);

    if (STAGE_COUNT == 0) begin : g_pass
        assign bus.OUT_VALID   = bus.IN_VALID & bus.CE;
        assign bus.OUT_CHANNEL = bus.IN_CHANNEL;
        assign bus.OUT_VALUE   = in_padded;

        logic unused_pass;
        assign unused_pass = ^{CLK, RESET, bus.SHIFT};
    end else begin : g_pipe
        localparam int S = STAGE_COUNT;

        logic                    accept;
        logic [3:0]              in_shift;
        logic                    in_prime;
        logic [NCH-1:0]          primed;

        logic [A-1:0]            acc     [S][NCH];
        logic                    q_valid [S];
        logic [CHANNEL_BITS-1:0] q_chan  [S];
        logic [3:0]              q_shift [S];
        logic                    q_prime [S];
        logic [W-1:0]            q_data  [S];

        logic                    s_valid [S];
        logic [CHANNEL_BITS-1:0] s_chan  [S];
        logic [3:0]              s_shift [S];
        logic                    s_prime [S];
        logic [A-1:0]            s_acc   [S];

        assign accept   = bus.CE & bus.IN_VALID;
        assign in_shift = (int'(bus.SHIFT) > MAX_SHIFT) ? 4'(MAX_SHIFT) : bus.SHIFT;
        assign in_prime = (PRIME_ON_FIRST != 0) && !primed[bus.IN_CHANNEL];

        for (genvar k = 0; k < S; k++) begin : g_stage
            logic [W-1:0]        x;
            logic [A-1:0]        cur;
            logic [A-1:0]        x_ext;
            logic signed [A:0]   diff;
            logic signed [A:0]   step;

            if (k == 0) begin : g_head
                assign s_valid[k] = accept;
                assign s_chan[k]  = bus.IN_CHANNEL;
                assign s_shift[k] = in_shift;
                assign s_prime[k] = in_prime;
                assign x          = in_padded;
            end else begin : g_link
                assign s_valid[k] = q_valid[k-1];
                assign s_chan[k]  = q_chan[k-1];
                assign s_shift[k] = q_shift[k-1];
                assign s_prime[k] = q_prime[k-1];
                assign x          = q_data[k-1];
            end

            // Adding the floored step keeps the result inside [0, 2^A-1], so modulo-2^A addition is exact.
            assign cur      = acc[k][s_chan[k]];
            assign x_ext    = A'(x) << F;
            assign diff     = $signed({1'b0, x_ext}) - $signed({1'b0, cur});
            assign step     = diff >>> s_shift[k];
            assign s_acc[k] = s_prime[k] ? x_ext : cur + step[A-1:0];

            logic unused_msb;
            assign unused_msb = step[A];
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                primed <= '0;
                for (int k = 0; k < S; k++) begin
                    q_valid[k] <= 1'b0;
                    q_chan[k]  <= '0;
                    q_shift[k] <= '0;
                    q_prime[k] <= 1'b0;
                    q_data[k]  <= '0;
                    for (int c = 0; c < NCH; c++) begin
                        acc[k][c] <= '0;
                    end
                end
            end else if (bus.CE) begin
                if (accept) begin
                    primed[bus.IN_CHANNEL] <= 1'b1;
                end
                for (int k = 0; k < S; k++) begin
                    q_valid[k] <= s_valid[k];
                    if (s_valid[k]) begin
                        acc[k][s_chan[k]] <= s_acc[k];
                        q_chan[k]         <= s_chan[k];
                        q_shift[k]        <= s_shift[k];
                        q_prime[k]        <= s_prime[k];
                        q_data[k]         <= s_acc[k][A-1:F];
                    end
                end
            end
        end

        assign bus.OUT_VALID   = q_valid[S-1];
        assign bus.OUT_CHANNEL = q_chan[S-1];
        assign bus.OUT_VALUE   = q_data[S-1];

        logic unused_tail;
        assign unused_tail = ^{q_shift[S-1], q_prime[S-1]};
    end
endmodule
